qdrii_test_sequencer: RTL and testbench
=======================================

// Module: qdrii_test_sequencer
// PURPOSE
//  On-chip sequencer for the M503 QDRII traffic-generator test, replacing host-side polling loops.
//  Sequences reset, calibration wait (with timeout), a timed traffic run and error collection for NUM_CH channels.
//  Sits on the PicoBus as a slave beside the per-channel QDRII controllers and traffic generators.
// PARAMETERS
//  NUM_CH       3             number of QDRII channels, 1..8
//  BASE_ADDR    32'h12350000  PicoBus base; regs at +0x00 CTRL/STAT, +0x10 RUN_LEN, +0x20 ERR, +0x30 CYCLES
//  RST_CYCLES   16            qdr_rst pulse length in PicoClk cycles, >=1
//  CAL_TIMEOUT  100000        max cycles in CAL_WAIT before failure
//  RUN_DEFAULT  5000          reset value of RUN_LEN
// PORTS
//  PicoClk      in   1        single clock; all logic on rising edge
//  PicoRst      in   1        synchronous, active-high reset
//  PicoAddr     in   32       PicoBus address
//  PicoDataIn   in   128      PicoBus write data
//  PicoWr       in   1        write strobe, one cycle
//  PicoRd       in   1        read strobe, one cycle
//  PicoDataOut  out  128      read data; zero when not addressed (OR-combined bus)
//  qdr_rst      out  NUM_CH   reset to each QDRII controller
//  cal_done     in   NUM_CH   per-channel calibration complete (level)
//  tg_enable    out  1        enables all traffic generators
//  tg_error     in   NUM_CH   per-channel traffic-generator error (level or pulse)
//  test_busy    out  1        high in RESET, CAL_WAIT, RUN
// BEHAVIOUR
//  Reset: state=IDLE, qdr_rst=0, tg_enable=0, PicoDataOut=0, ERR=0, flags=0, CYCLES=0, RUN_LEN=RUN_DEFAULT.
//  Register access: write takes effect the edge PicoWr is sampled; PicoDataOut valid the cycle after PicoRd
//   with matching address, 0 every other cycle. Unmapped addresses: writes ignored, read returns 0.
//  CTRL write: bit0 START, bit1 ABORT (self-clearing commands). RUN_LEN write: [31:0].
//  CTRL read: [2:0] state, [15:8] cal_done (zero-ext), [16] cal_timeout, [17] cal_lost, [18] pass.
//  ERR read: [NUM_CH-1:0] sticky error flags; write 1 to clear a bit. CYCLES read: [31:0] RUN cycles elapsed.
//  States (encoding): IDLE=0, RESET=1, CAL_WAIT=2, RUN=3, DONE=4, FAIL=5.
//  IDLE/DONE/FAIL + START -> RESET: clears ERR, flags, CYCLES, pass; qdr_rst all-ones for RST_CYCLES cycles.
//  RESET -> CAL_WAIT after RST_CYCLES; qdr_rst deasserts on that edge.
//  CAL_WAIT: all cal_done high -> RUN (tg_enable=1 next cycle); counter reaches CAL_TIMEOUT -> FAIL, cal_timeout=1.
//  RUN: CYCLES increments each cycle; CYCLES==RUN_LEN-1 -> DONE, tg_enable=0. RUN_LEN==0 -> CAL_WAIT goes
//   straight to DONE, tg_enable never asserted. Any cal_done bit low in RUN -> FAIL, cal_lost=1, tg_enable=0.
//  ERR bits set from tg_error only in RUN; set dominates a same-cycle write-1-clear.
//  DONE: pass=1 iff ERR==0 at entry. DONE/FAIL hold until START.
//  START while test_busy: ignored. ABORT in any state -> IDLE next cycle, qdr_rst=0, tg_enable=0; ERR/flags kept.
//  START and ABORT in the same write: ABORT wins. RUN_LEN write during RUN: ignored (sampled at RUN entry).
//  PicoRst mid-operation: immediate return to reset values on next edge, regardless of state.
//  CYCLES saturates at 32'hFFFFFFFF (no wrap).
// TESTING
//  1. Reset, read CTRL -> 0; RUN_LEN read -> 5000; ERR -> 0; qdr_rst=0, tg_enable=0.
//  2. RUN_LEN=100, START, cal_done=3'b111 at cycle 40 -> qdr_rst high exactly 16 cycles, tg_enable high exactly
//     100 cycles, CTRL state=4, pass=1, CYCLES=100.
//  3. As 2, tg_error[1] pulse at RUN cycle 50 -> ERR=3'b010, pass=0; write ERR=2 -> ERR=0.
//  4. cal_done stuck 3'b011, CAL_TIMEOUT=200 -> FAIL after 200 cycles in CAL_WAIT, cal_timeout=1, tg_enable never high.
//  5. cal_done[2] drops at RUN cycle 30 -> FAIL next cycle, cal_lost=1; START again -> flags cleared, RESET entered.
//  6. ABORT during RUN; PicoRst during CAL_WAIT; START+ABORT together; RUN_LEN=0 -> IDLE/reset values/IDLE/DONE, pass=1.

Source files
------------

// File: rtl/qdrii_test_sequencer_if.sv
// PicoBus slave port bundle: address/data/strobes from the host side,
// OR-combined read data back from each slave.
interface qdrii_test_sequencer_if;
   logic [31:0]  PicoAddr;
   logic [127:0] PicoDataIn;
   logic         PicoWr;
   logic         PicoRd;
   logic [127:0] PicoDataOut;

   modport master (
      output PicoAddr, PicoDataIn, PicoWr, PicoRd,
      input  PicoDataOut
   );

   modport slave (
      input  PicoAddr, PicoDataIn, PicoWr, PicoRd,
      output PicoDataOut
   );
endinterface

// File: rtl/qdrii_test_sequencer.sv
// On-chip QDRII traffic-test sequencer: drives controller resets, waits for
// calibration with a timeout, runs the traffic generators for RUN_LEN cycles
// and collects sticky per-channel errors. Controlled over PicoBus.
module qdrii_test_sequencer #(
   parameter int unsigned NUM_CH      = 3,
   parameter logic [31:0] BASE_ADDR   = 32'h12350000,
   parameter int unsigned RST_CYCLES  = 16,
   parameter int unsigned CAL_TIMEOUT = 100000,
   parameter logic [31:0] RUN_DEFAULT = 32'd5000
) (
   input  logic                  PicoClk,
   input  logic                  PicoRst,
   qdrii_test_sequencer_if.slave pico,
   output logic [NUM_CH-1:0]     qdr_rst,
   input  logic [NUM_CH-1:0]     cal_done,
   output logic                  tg_enable,
   input  logic [NUM_CH-1:0]     tg_error,
   output logic                  test_busy
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RESET    = 3'd1,
      S_CAL_WAIT = 3'd2,
      S_RUN      = 3'd3,
      S_DONE     = 3'd4,
      S_FAIL     = 3'd5
   } state_t;

   localparam logic [31:0] A_CTRL   = BASE_ADDR;
   localparam logic [31:0] A_RUNLEN = BASE_ADDR + 32'h10;
   localparam logic [31:0] A_ERR    = BASE_ADDR + 32'h20;
   localparam logic [31:0] A_CYCLES = BASE_ADDR + 32'h30;
   localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
   localparam logic [31:0] CAL_LAST = 32'(CAL_TIMEOUT - 1);

   state_t              state_q, state_d;
   logic [31:0]         cnt_q, cnt_d;          // RESET / CAL_WAIT dwell counter
   logic [31:0]         run_len_q, run_len_d;  // host-visible RUN_LEN
   logic [31:0]         run_lat_q, run_lat_d;  // RUN_LEN captured at RUN entry
   logic [31:0]         cycles_q, cycles_d;
   logic [NUM_CH-1:0]   err_q, err_d;
   logic                cal_timeout_q, cal_timeout_d;
   logic                cal_lost_q, cal_lost_d;
   logic                pass_q, pass_d;
   logic [127:0]        rdata_q, rdata_d;

   logic                wr_ctrl, wr_runlen, wr_err;
   logic                start_cmd, abort_cmd, all_cal;
   logic [NUM_CH-1:0]   err_clr;
   logic                unused_data_bits;

   assign wr_ctrl   = pico.PicoWr && (pico.PicoAddr == A_CTRL);
   assign wr_runlen = pico.PicoWr && (pico.PicoAddr == A_RUNLEN);
   assign wr_err    = pico.PicoWr && (pico.PicoAddr == A_ERR);
   assign start_cmd = wr_ctrl && pico.PicoDataIn[0];
   assign abort_cmd = wr_ctrl && pico.PicoDataIn[1];
   assign all_cal   = &cal_done;
   assign err_clr   = wr_err ? pico.PicoDataIn[NUM_CH-1:0] : '0;
   assign unused_data_bits = ^pico.PicoDataIn[127:32];

   // Next-state, command handling and register updates.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      run_len_d     = run_len_q;
      run_lat_d     = run_lat_q;
      cycles_d      = cycles_q;
      cal_timeout_d = cal_timeout_q;
      cal_lost_d    = cal_lost_q;
      pass_d        = pass_q;

      // RUN_LEN is frozen while a run is in progress.
      if (wr_runlen && (state_q != S_RUN))
         run_len_d = pico.PicoDataIn[31:0];

      // Error capture wins over a same-cycle write-1-clear.
      err_d = err_q & ~err_clr;
      if (state_q == S_RUN)
         err_d = err_d | tg_error;

      if ((state_q == S_RUN) && (cycles_q != 32'hFFFF_FFFF))
         cycles_d = cycles_q + 32'd1;

      if (abort_cmd) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
               if (start_cmd) begin
                  state_d       = S_RESET;
                  cnt_d         = '0;
                  err_d         = '0;
                  cycles_d      = '0;
                  cal_timeout_d = 1'b0;
                  cal_lost_d    = 1'b0;
                  pass_d        = 1'b0;
               end
            end
            S_RESET: begin
               if (cnt_q == RST_LAST) begin
                  state_d = S_CAL_WAIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            S_CAL_WAIT: begin
               if (all_cal) begin
                  if (run_len_q == 32'd0) begin
                     state_d = S_DONE;
                     pass_d  = (err_d == '0);
                  end else begin
                     state_d   = S_RUN;
                     run_lat_d = run_len_q;
                  end
               end else if (cnt_q == CAL_LAST) begin
                  state_d       = S_FAIL;
                  cal_timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            S_RUN: begin
               if (!all_cal) begin
                  state_d    = S_FAIL;
                  cal_lost_d = 1'b1;
               end else if (cycles_q == (run_lat_q - 32'd1)) begin
                  state_d = S_DONE;
                  pass_d  = (err_d == '0);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Read data is registered and zero whenever this slave is not addressed.
   always_comb begin
      rdata_d = '0;
      if (pico.PicoRd) begin
         case (pico.PicoAddr)
            A_CTRL: begin
               rdata_d[2:0]         = state_q;
               rdata_d[8 +: NUM_CH] = cal_done;
               rdata_d[16]          = cal_timeout_q;
               rdata_d[17]          = cal_lost_q;
               rdata_d[18]          = pass_q;
            end
            A_RUNLEN: rdata_d[31:0]         = run_len_q;
            A_ERR:    rdata_d[NUM_CH-1:0]   = err_q;
            A_CYCLES: rdata_d[31:0]         = cycles_q;
            default:  rdata_d               = '0;
         endcase
      end
   end

   // State and register flops with synchronous reset.
   always_ff @(posedge PicoClk) begin
      if (PicoRst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         run_len_q     <= RUN_DEFAULT;
         run_lat_q     <= '0;
         cycles_q      <= '0;
         err_q         <= '0;
         cal_timeout_q <= 1'b0;
         cal_lost_q    <= 1'b0;
         pass_q        <= 1'b0;
         rdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         run_len_q     <= run_len_d;
         run_lat_q     <= run_lat_d;
         cycles_q      <= cycles_d;
         err_q         <= err_d;
         cal_timeout_q <= cal_timeout_d;
         cal_lost_q    <= cal_lost_d;
         pass_q        <= pass_d;
         rdata_q       <= rdata_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_qdr_rst
         assign qdr_rst[gi] = (state_q == S_RESET);
      end
   endgenerate

   assign tg_enable        = (state_q == S_RUN);
   assign test_busy        = (state_q == S_RESET) || (state_q == S_CAL_WAIT) || (state_q == S_RUN);
   assign pico.PicoDataOut = rdata_q;

endmodule

// File: tb/tb_qdrii_test_sequencer.sv
// Scoreboard bench for qdrii_test_sequencer: reads push the value the
// reference model predicts, a monitor pops and compares the returned data.
module tb_qdrii_test_sequencer;
   localparam int NCH = 3;
   localparam int RSTC = 16;
   localparam int CAL_TO = 200;
   localparam logic [31:0] BASE = 32'h12350000;
   localparam logic [31:0] A_CTRL = BASE;
   localparam logic [31:0] A_RL = BASE + 32'h10;
   localparam logic [31:0] A_ERR = BASE + 32'h20;
   localparam logic [31:0] A_CYC = BASE + 32'h30;
   localparam logic [NCH-1:0] ALL = '1;

   logic clk = 1'b0;
   logic rst;
   logic [NCH-1:0] cal_done, tg_error;
   wire  [NCH-1:0] qdr_rst;
   wire  tg_enable, test_busy;

   qdrii_test_sequencer_if bus();

   always #5 clk = ~clk;

   qdrii_test_sequencer #(
      .NUM_CH(NCH), .BASE_ADDR(BASE), .RST_CYCLES(RSTC),
      .CAL_TIMEOUT(CAL_TO), .RUN_DEFAULT(32'd5000)
   ) dut (
      .PicoClk(clk), .PicoRst(rst), .pico(bus),
      .qdr_rst(qdr_rst), .cal_done(cal_done), .tg_enable(tg_enable),
      .tg_error(tg_error), .test_busy(test_busy)
   );

   int n_checks = 0;
   int n_fail = 0;
   logic [127:0] exp_q[$];
   string        name_q[$];
   int qdr_cnt = 0, tg_cnt = 0, cw_cnt = 0;
   logic [NCH-1:0] exp_err;
   int rl_model = 5000;

   function automatic void check(string nm, logic [127:0] act, logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endfunction

   function automatic logic [127:0] ctrl_word(int st, logic [NCH-1:0] cal, bit to, bit lost, bit pass);
      logic [127:0] w;
      w = '0;
      w[2:0] = 3'(st);
      w[8 +: NCH] = cal;
      w[16] = to;
      w[17] = lost;
      w[18] = pass;
      return w;
   endfunction

   // All driver tasks start and end on a falling edge.
   task automatic bus_write(logic [31:0] a, logic [127:0] d);
      bus.PicoAddr = a; bus.PicoDataIn = d; bus.PicoWr = 1'b1;
      $display("[%0t] wr addr=%h data=%0h", $time, a, d);
      @(negedge clk);
      bus.PicoWr = 1'b0;
   endtask

   task automatic bus_read(logic [31:0] a, logic [127:0] exp, string nm);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      bus.PicoAddr = a; bus.PicoRd = 1'b1;
      $display("[%0t] rd addr=%h expect=%0h", $time, a, exp);
      @(negedge clk);
      bus.PicoRd = 1'b0;
   endtask

   task automatic wait_qdr_low();
      for (int i = 0; i < RSTC + 5 && qdr_rst != '0; i++) @(negedge clk);
      check("qdr_rst_release", 128'(qdr_rst), 128'(0));
   endtask

   task automatic wait_tg_high();
      for (int i = 0; i < 60 && !tg_enable; i++) @(negedge clk);
      check("tg_enable_rise", 128'(tg_enable), 128'(1));
   endtask

   // Monitor: read data the cycle after a read strobe, zero otherwise.
   initial begin
      logic rd_seen;
      forever begin
         @(posedge clk);
         rd_seen = bus.PicoRd;
         @(negedge clk);
         if (rd_seen) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL rd_unexpected: got %0h, expected no response", bus.PicoDataOut);
            end else begin
               check(name_q.pop_front(), bus.PicoDataOut, exp_q.pop_front());
            end
         end else begin
            check("rdata_idle", bus.PicoDataOut, 128'(0));
         end
      end
   end

   // Pulse-length counters and qdr_rst shape (all channels together).
   always @(negedge clk) begin
      if (qdr_rst != '0) qdr_cnt++;
      if (tg_enable) tg_cnt++;
      if (test_busy && qdr_rst == '0 && !tg_enable) cw_cnt++;
      if (qdr_rst != '0) check("qdr_rst_shape", 128'(qdr_rst), 128'(ALL));
   end

   // One full test: RESET, CAL_WAIT of d+1 cycles, RUN of run_len cycles.
   task automatic run_test(int run_len, int d, bit inj, int ch, int at, logic [NCH-1:0] pre);
      int i;
      cal_done = '0;
      bus_write(A_RL, 128'(run_len));
      rl_model = run_len;
      qdr_cnt = 0; tg_cnt = 0; cw_cnt = 0;
      exp_err = '0;
      bus_write(A_CTRL, 128'(1));
      check("busy_after_start", 128'(test_busy), 128'(1));
      wait_qdr_low();
      tg_error = pre;
      repeat (d) @(negedge clk);
      cal_done = ALL;
      @(negedge clk);
      for (i = 0; i < run_len + 5 && tg_enable; i++) begin
         tg_error = '0;
         if (inj && i == at) begin
            tg_error[ch] = 1'b1;
            exp_err[ch] = 1'b1;
         end
         @(negedge clk);
      end
      tg_error = '0;
      check("run_terminated", 128'(tg_enable), 128'(0));
      check("qdr_rst_len", 128'(qdr_cnt), 128'(RSTC));
      check("cal_wait_len", 128'(cw_cnt), 128'(d + 1));
      check("tg_enable_len", 128'(tg_cnt), 128'(run_len));
      check("busy_done", 128'(test_busy), 128'(0));
      bus_read(A_CTRL, ctrl_word(4, ALL, 0, 0, exp_err == '0), "ctrl_done");
      bus_read(A_ERR, 128'(exp_err), "err_done");
      bus_read(A_CYC, 128'(run_len), "cycles_done");
      if (exp_err != '0) begin
         logic [NCH-1:0] m;
         m = NCH'($urandom_range(1, (1 << NCH) - 1));
         bus_write(A_ERR, 128'(m));
         exp_err = exp_err & ~m;
         bus_read(A_ERR, 128'(exp_err), "err_clear");
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NCH-1:0] cd, bit_m;
      int k;
      rst = 1'b1; cal_done = '0; tg_error = '0;
      bus.PicoAddr = '0; bus.PicoDataIn = '0; bus.PicoWr = 1'b0; bus.PicoRd = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset values.
      check("qdr_rst_reset", 128'(qdr_rst), 128'(0));
      check("tg_enable_reset", 128'(tg_enable), 128'(0));
      check("busy_reset", 128'(test_busy), 128'(0));
      bus_read(A_CTRL, 128'(0), "ctrl_reset");
      bus_read(A_RL, 128'(5000), "runlen_reset");
      bus_read(A_ERR, 128'(0), "err_reset");
      bus_read(A_CYC, 128'(0), "cycles_reset");
      bus_read(BASE + 32'h40, 128'(0), "unmapped_read");
      bus_write(BASE + 32'h14, 128'(77));
      bus_read(A_RL, 128'(5000), "unmapped_write");

      // Clean run, then a run with a single error, then randomized runs.
      run_test(100, 23, 0, 0, 0, '0);
      run_test(100, 10, 1, 1, 50, 3'b101);
      for (int it = 0; it < 5; it++) begin
         int rl, at;
         rl = $urandom_range(1, 150);
         at = $urandom_range(0, rl - 1);
         run_test(rl, $urandom_range(0, 60), $urandom_range(0, 1), $urandom_range(0, NCH - 1),
                  at, NCH'($urandom_range(0, (1 << NCH) - 1)));
      end
      run_test(1, 3, 1, 2, 0, '0);

      // Calibration timeout.
      cd = 3'b011;
      cal_done = cd;
      qdr_cnt = 0; tg_cnt = 0; cw_cnt = 0;
      bus_write(A_CTRL, 128'(1));
      wait_qdr_low();
      for (int i = 0; i < CAL_TO + 20 && test_busy; i++) @(negedge clk);
      check("timeout_busy", 128'(test_busy), 128'(0));
      check("timeout_len", 128'(cw_cnt), 128'(CAL_TO));
      check("timeout_tg", 128'(tg_cnt), 128'(0));
      bus_read(A_CTRL, ctrl_word(5, cd, 1, 0, 0), "ctrl_timeout");

      // Calibration lost in RUN at cycle 30.
      k = $urandom_range(0, NCH - 1);
      bit_m = '0; bit_m[k] = 1'b1;
      cal_done = '0;
      bus_write(A_RL, 128'(100));
      rl_model = 100;
      qdr_cnt = 0; tg_cnt = 0; cw_cnt = 0;
      bus_write(A_CTRL, 128'(1));
      wait_qdr_low();
      repeat (5) @(negedge clk);
      cal_done = ALL;
      wait_tg_high();
      for (int i = 0; i < 110 && tg_enable; i++) begin
         if (i == 30) cal_done = ALL & ~bit_m;
         @(negedge clk);
      end
      check("lost_tg_len", 128'(tg_cnt), 128'(31));
      check("lost_busy", 128'(test_busy), 128'(0));
      bus_read(A_CTRL, ctrl_word(5, ALL & ~bit_m, 0, 1, 0), "ctrl_cal_lost");

      // Restart from FAIL clears flags; then abort in RUN.
      bus_write(A_CTRL, 128'(1));
      bus_read(A_CTRL, ctrl_word(1, ALL & ~bit_m, 0, 0, 0), "ctrl_restart");
      cal_done = ALL;
      wait_qdr_low();
      wait_tg_high();
      exp_err = bit_m;
      tg_error = bit_m;
      bus_write(A_ERR, 128'(bit_m));
      tg_error = '0;
      bus_write(A_RL, 128'(7));
      bus_write(A_CTRL, 128'(2));
      check("abort_tg", 128'(tg_enable), 128'(0));
      check("abort_busy", 128'(test_busy), 128'(0));
      bus_read(A_CTRL, ctrl_word(0, ALL, 0, 0, 0), "ctrl_abort");
      bus_read(A_ERR, 128'(exp_err), "err_kept_abort");
      bus_read(A_RL, 128'(rl_model), "runlen_frozen");

      // PicoRst during CAL_WAIT.
      cal_done = '0;
      bus_write(A_RL, 128'(33));
      bus_write(A_CTRL, 128'(1));
      wait_qdr_low();
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 128'(test_busy), 128'(0));
      check("rst_qdr", 128'(qdr_rst), 128'(0));
      bus_read(A_CTRL, 128'(0), "ctrl_after_rst");
      bus_read(A_RL, 128'(5000), "runlen_after_rst");
      bus_read(A_ERR, 128'(0), "err_after_rst");

      // START and ABORT together: ABORT wins.
      cal_done = ALL;
      bus_write(A_CTRL, 128'(3));
      check("start_abort_busy", 128'(test_busy), 128'(0));
      check("start_abort_qdr", 128'(qdr_rst), 128'(0));
      bus_read(A_CTRL, ctrl_word(0, ALL, 0, 0, 0), "ctrl_start_abort");

      // RUN_LEN = 0: straight to DONE, traffic never enabled.
      run_test(0, 0, 0, 0, 0, '0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
